// File: rtl/cpu_run_ctrl.sv
// Host-side run controller: loads instruction/data memory through the CPU's
// external ports, runs the CPU for a set number of cycles, then streams a data window back.
module cpu_run_ctrl #(
    parameter int RUN_W = 16
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [8:0]       imem_len,
    input  logic [9:0]       dmem_len,
    input  logic [RUN_W-1:0] run_cycles,
    input  logic [9:0]       dump_len,
    input  logic             ld_valid,
    output logic             ld_ready,
    input  logic [63:0]      ld_data,
    output logic             dump_valid,
    input  logic             dump_ready,
    output logic [63:0]      dump_data,
    output logic             cpu_enable,
    output logic [63:0]      addr_ext,
    output logic             wen_ext,
    output logic             ren_ext,
    output logic [31:0]      wdata_ext,
    output logic [63:0]      addr_ext_2,
    output logic             wen_ext_2,
    output logic             ren_ext_2,
    output logic [63:0]      wdata_ext_2,
    input  logic [63:0]      rdata_ext_2,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_LOAD_I   = 3'd1;
    localparam logic [2:0] S_LOAD_D   = 3'd2;
    localparam logic [2:0] S_RUN      = 3'd3;
    localparam logic [2:0] S_DUMP_RD  = 3'd4;
    localparam logic [2:0] S_DUMP_CAP = 3'd5;
    localparam logic [2:0] S_DUMP_OUT = 3'd6;
    localparam logic [2:0] S_DONE     = 3'd7;

    localparam logic [RUN_W-1:0] RUN_ONE = {{(RUN_W-1){1'b0}}, 1'b1};
    localparam logic [9:0]       IDX_ONE = 10'd1;

    logic [2:0]       state_q, state_d;
    logic [9:0]       idx_q, idx_d;
    logic [RUN_W-1:0] cnt_q, cnt_d;
    logic [8:0]       imem_len_q, imem_len_d;
    logic [9:0]       dmem_len_q, dmem_len_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic [9:0]       dump_len_q, dump_len_d;
    logic             cpu_enable_q, cpu_enable_d;
    logic             wen_ext_q, wen_ext_d;
    logic [63:0]      addr_ext_q, addr_ext_d;
    logic [31:0]      wdata_ext_q, wdata_ext_d;
    logic             wen_ext_2_q, wen_ext_2_d;
    logic             ren_ext_2_q, ren_ext_2_d;
    logic [63:0]      addr_ext_2_q, addr_ext_2_d;
    logic [63:0]      wdata_ext_2_q, wdata_ext_2_d;
    logic             dump_valid_q, dump_valid_d;
    logic [63:0]      dump_data_q, dump_data_d;
    logic             beat;

    // Stage order is fixed; this picks the first later stage that has work to do.
    function automatic logic [2:0] stage_after(input logic [2:0] cur, input logic i_nz,
                                               input logic d_nz, input logic r_nz,
                                               input logic u_nz);
        if (cur < S_LOAD_I && i_nz)       return S_LOAD_I;
        else if (cur < S_LOAD_D && d_nz)  return S_LOAD_D;
        else if (cur < S_RUN && r_nz)     return S_RUN;
        else if (cur < S_DUMP_RD && u_nz) return S_DUMP_RD;
        else                              return S_DONE;
    endfunction

    assign ld_ready = (state_q == S_LOAD_I) || (state_q == S_LOAD_D);
    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);
    assign beat     = ld_valid && ld_ready;

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        cnt_d         = cnt_q;
        imem_len_d    = imem_len_q;
        dmem_len_d    = dmem_len_q;
        run_d         = run_q;
        dump_len_d    = dump_len_q;
        wen_ext_d     = 1'b0;
        addr_ext_d    = addr_ext_q;
        wdata_ext_d   = wdata_ext_q;
        wen_ext_2_d   = 1'b0;
        addr_ext_2_d  = addr_ext_2_q;
        wdata_ext_2_d = wdata_ext_2_q;
        dump_data_d   = dump_data_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    imem_len_d = imem_len;
                    dmem_len_d = dmem_len;
                    run_d      = run_cycles;
                    dump_len_d = dump_len;
                    state_d    = stage_after(S_IDLE, |imem_len, |dmem_len,
                                             |run_cycles, |dump_len);
                end
            end
            S_LOAD_I: begin
                if (beat) begin
                    wen_ext_d   = 1'b1;
                    addr_ext_d  = {52'd0, idx_q, 2'b00};
                    wdata_ext_d = ld_data[31:0];
                    if (idx_q == {1'b0, imem_len_q} - IDX_ONE) begin
                        idx_d   = 10'd0;
                        state_d = stage_after(S_LOAD_I, 1'b0, |dmem_len_q, |run_q, |dump_len_q);
                    end else begin
                        idx_d = idx_q + IDX_ONE;
                    end
                end
            end
            S_LOAD_D: begin
                if (beat) begin
                    wen_ext_2_d   = 1'b1;
                    addr_ext_2_d  = {51'd0, idx_q, 3'b000};
                    wdata_ext_2_d = ld_data;
                    if (idx_q == dmem_len_q - IDX_ONE) begin
                        idx_d   = 10'd0;
                        state_d = stage_after(S_LOAD_D, 1'b0, 1'b0, |run_q, |dump_len_q);
                    end else begin
                        idx_d = idx_q + IDX_ONE;
                    end
                end
            end
            S_RUN: begin
                // Only enabled cycles count, so a trailing load write delays the run without shortening it.
                if (cpu_enable_q) begin
                    if (cnt_q == run_q - RUN_ONE) begin
                        cnt_d   = '0;
                        state_d = stage_after(S_RUN, 1'b0, 1'b0, 1'b0, |dump_len_q);
                    end else begin
                        cnt_d = cnt_q + RUN_ONE;
                    end
                end
            end
            S_DUMP_RD: begin
                if (ren_ext_2_q) state_d = S_DUMP_CAP;
            end
            S_DUMP_CAP: begin
                dump_data_d = rdata_ext_2;
                state_d     = S_DUMP_OUT;
            end
            S_DUMP_OUT: begin
                if (dump_ready) begin
                    if (idx_q == dump_len_q - IDX_ONE) begin
                        idx_d   = 10'd0;
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + IDX_ONE;
                        state_d = S_DUMP_RD;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (abort) begin
            state_d     = S_IDLE;
            idx_d       = 10'd0;
            cnt_d       = '0;
            wen_ext_d   = 1'b0;
            wen_ext_2_d = 1'b0;
        end

        // Strobes are issued only when no memory write is pending, keeping them exclusive with enable.
        ren_ext_2_d = (state_d == S_DUMP_RD) && !wen_ext_2_d;
        if (ren_ext_2_d) addr_ext_2_d = {51'd0, idx_d, 3'b000};
        cpu_enable_d = (state_d == S_RUN) && !wen_ext_d && !wen_ext_2_d;
        dump_valid_d = (state_d == S_DUMP_OUT);
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q       <= S_IDLE;
            idx_q         <= '0;
            cnt_q         <= '0;
            imem_len_q    <= '0;
            dmem_len_q    <= '0;
            run_q         <= '0;
            dump_len_q    <= '0;
            cpu_enable_q  <= 1'b0;
            wen_ext_q     <= 1'b0;
            addr_ext_q    <= '0;
            wdata_ext_q   <= '0;
            wen_ext_2_q   <= 1'b0;
            ren_ext_2_q   <= 1'b0;
            addr_ext_2_q  <= '0;
            wdata_ext_2_q <= '0;
            dump_valid_q  <= 1'b0;
            dump_data_q   <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            cnt_q         <= cnt_d;
            imem_len_q    <= imem_len_d;
            dmem_len_q    <= dmem_len_d;
            run_q         <= run_d;
            dump_len_q    <= dump_len_d;
            cpu_enable_q  <= cpu_enable_d;
            wen_ext_q     <= wen_ext_d;
            addr_ext_q    <= addr_ext_d;
            wdata_ext_q   <= wdata_ext_d;
            wen_ext_2_q   <= wen_ext_2_d;
            ren_ext_2_q   <= ren_ext_2_d;
            addr_ext_2_q  <= addr_ext_2_d;
            wdata_ext_2_q <= wdata_ext_2_d;
            dump_valid_q  <= dump_valid_d;
            dump_data_q   <= dump_data_d;
        end
    end

    assign cpu_enable  = cpu_enable_q;
    assign wen_ext     = wen_ext_q;
    assign ren_ext     = 1'b0;
    assign addr_ext    = addr_ext_q;
    assign wdata_ext   = wdata_ext_q;
    assign wen_ext_2   = wen_ext_2_q;
    assign ren_ext_2   = ren_ext_2_q;
    assign addr_ext_2  = addr_ext_2_q;
    assign wdata_ext_2 = wdata_ext_2_q;
    assign dump_valid  = dump_valid_q;
    assign dump_data   = dump_data_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl with a small data-memory model behind the
// second external port.
module tb_cpu_run_ctrl;

    localparam int RUN_W = 16;
    localparam logic [63:0] BASE = 64'h1111_0000_0000_0000;

    logic             clk = 1'b0;
    logic             arst_n;
    logic             start, abort;
    logic [8:0]       imem_len;
    logic [9:0]       dmem_len;
    logic [RUN_W-1:0] run_cycles;
    logic [9:0]       dump_len;
    logic             ld_valid, ld_ready;
    logic [63:0]      ld_data;
    logic             dump_valid, dump_ready;
    logic [63:0]      dump_data;
    logic             cpu_enable;
    logic [63:0]      addr_ext;
    logic             wen_ext, ren_ext;
    logic [31:0]      wdata_ext;
    logic [63:0]      addr_ext_2;
    logic             wen_ext_2, ren_ext_2;
    logic [63:0]      wdata_ext_2;
    logic [63:0]      rdata_ext_2;
    logic             busy, done;

    logic [63:0] dmem [0:1023];

    int pass_cnt   = 0;
    int check_cnt  = 0;
    int excl_viol  = 0;
    int addr_viol  = 0;

    always #5 clk = ~clk;

    cpu_run_ctrl #(.RUN_W(RUN_W)) dut (
        .clk(clk), .arst_n(arst_n), .start(start), .abort(abort),
        .imem_len(imem_len), .dmem_len(dmem_len), .run_cycles(run_cycles),
        .dump_len(dump_len), .ld_valid(ld_valid), .ld_ready(ld_ready),
        .ld_data(ld_data), .dump_valid(dump_valid), .dump_ready(dump_ready),
        .dump_data(dump_data), .cpu_enable(cpu_enable), .addr_ext(addr_ext),
        .wen_ext(wen_ext), .ren_ext(ren_ext), .wdata_ext(wdata_ext),
        .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2), .ren_ext_2(ren_ext_2),
        .wdata_ext_2(wdata_ext_2), .rdata_ext_2(rdata_ext_2),
        .busy(busy), .done(done)
    );

    // Data memory: write lands on the strobe edge, read data appears the cycle after ren.
    always @(posedge clk) begin
        if (wen_ext_2) dmem[addr_ext_2[12:3]] <= wdata_ext_2;
        if (ren_ext_2) rdata_ext_2 <= dmem[addr_ext_2[12:3]];
    end

    always @(negedge clk) begin
        if (arst_n && cpu_enable && (wen_ext || ren_ext || wen_ext_2 || ren_ext_2))
            excl_viol++;
        if (addr_ext[63:12] != 52'd0 || addr_ext_2[63:13] != 51'd0)
            addr_viol++;
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        check_cnt++;
        if (observed === expected) pass_cnt++;
        else $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [8:0] il, input logic [9:0] dl,
                                 input logic [RUN_W-1:0] rc, input logic [9:0] ul);
        imem_len   = il;
        dmem_len   = dl;
        run_cycles = rc;
        dump_len   = ul;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    // Steps until idle, counting activity; ld_data follows BASE + beat number.
    task automatic runAndCount(input int budget, input bit poke, output int en_cnt,
                               output int done_cnt, output int wi_cnt, output int wd_cnt,
                               output int dump_cnt, output logic [63:0] dump_word);
        int beats;
        bit poked;
        beats = 0; poked = 0;
        en_cnt = 0; done_cnt = 0; wi_cnt = 0; wd_cnt = 0; dump_cnt = 0;
        dump_word = '0;
        for (int i = 0; i < budget && busy; i++) begin
            if (poke && cpu_enable && !poked) begin
                start      = 1'b1;
                run_cycles = 16'd1;
                poked      = 1'b1;
            end
            ld_data = BASE + 64'(beats);
            if (ld_valid && ld_ready) beats++;
            if (dump_valid && dump_ready) begin
                dump_cnt++;
                dump_word = dump_data;
            end
            tick();
            start = 1'b0;
            if (cpu_enable) en_cnt++;
            if (done)       done_cnt++;
            if (wen_ext)    wi_cnt++;
            if (wen_ext_2)  wd_cnt++;
        end
        checkOutput("run_timeout_busy", {63'd0, busy}, 64'd0);
    endtask

    int en_c, done_c, wi_c, wd_c, dump_c;
    logic [63:0] dword;

    initial begin
        arst_n = 1'b0; start = 1'b0; abort = 1'b0;
        imem_len = '0; dmem_len = '0; run_cycles = '0; dump_len = '0;
        ld_valid = 1'b0; ld_data = '0; dump_ready = 1'b0;

        #12;
        checkOutput("rst_busy",       {63'd0, busy},       64'd0);
        checkOutput("rst_ld_ready",   {63'd0, ld_ready},   64'd0);
        checkOutput("rst_cpu_enable", {63'd0, cpu_enable}, 64'd0);
        checkOutput("rst_wen_ext",    {63'd0, wen_ext},    64'd0);
        checkOutput("rst_dump_valid", {63'd0, dump_valid}, 64'd0);
        checkOutput("rst_done",       {63'd0, done},       64'd0);
        @(negedge clk);
        arst_n = 1'b1;
        tick();

        // Load three instruction words, run five cycles.
        applyStimulus(9'd3, 10'd0, 16'd5, 10'd0);
        checkOutput("t1_ld_ready", {63'd0, ld_ready}, 64'd1);
        ld_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            ld_data = {32'hDEAD_BEEF, 32'h0010_0093 + 32'(k)};
            tick();
            checkOutput($sformatf("t1_wen%0d", k), {63'd0, wen_ext}, 64'd1);
            checkOutput($sformatf("t1_addr%0d", k), addr_ext, 64'(4 * k));
            checkOutput($sformatf("t1_wdata%0d", k), {32'd0, wdata_ext},
                        {32'd0, 32'h0010_0093 + 32'(k)});
        end
        ld_valid = 1'b0;
        checkOutput("t1_enable_off_during_write", {63'd0, cpu_enable}, 64'd0);
        runAndCount(40, 1'b0, en_c, done_c, wi_c, wd_c, dump_c, dword);
        checkOutput("t1_enable_cycles", 64'(en_c), 64'd5);
        checkOutput("t1_done_pulses",   64'(done_c), 64'd1);
        checkOutput("t1_extra_writes",  64'(wi_c), 64'd0);

        // Two data words, read back with backpressure on word 0.
        applyStimulus(9'd0, 10'd2, 16'd0, 10'd2);
        ld_valid = 1'b1;
        ld_data  = 64'hA5A5_A5A5_A5A5_A5A5;
        tick();
        checkOutput("t2_wen2_0",  {63'd0, wen_ext_2}, 64'd1);
        checkOutput("t2_addr2_0", addr_ext_2, 64'd0);
        checkOutput("t2_wdata2_0", wdata_ext_2, 64'hA5A5_A5A5_A5A5_A5A5);
        ld_data = 64'h0000_0000_0000_1234;
        tick();
        ld_valid = 1'b0;
        checkOutput("t2_wen2_1",  {63'd0, wen_ext_2}, 64'd1);
        checkOutput("t2_addr2_1", addr_ext_2, 64'd8);
        checkOutput("t2_ren_not_with_write", {63'd0, ren_ext_2}, 64'd0);
        tick();
        checkOutput("t2_ren0",      {63'd0, ren_ext_2}, 64'd1);
        checkOutput("t2_ren0_addr", addr_ext_2, 64'd0);
        tick();
        checkOutput("t2_cap_valid", {63'd0, dump_valid}, 64'd0);
        tick();
        for (int s = 0; s < 4; s++) begin
            checkOutput($sformatf("t2_stall_valid%0d", s), {63'd0, dump_valid}, 64'd1);
            checkOutput($sformatf("t2_stall_data%0d", s), dump_data, 64'hA5A5_A5A5_A5A5_A5A5);
            tick();
        end
        dump_ready = 1'b1;
        tick();
        checkOutput("t2_valid_drop",  {63'd0, dump_valid}, 64'd0);
        checkOutput("t2_ren1",        {63'd0, ren_ext_2}, 64'd1);
        checkOutput("t2_ren1_addr",   addr_ext_2, 64'd8);
        tick();
        tick();
        checkOutput("t2_word1_valid", {63'd0, dump_valid}, 64'd1);
        checkOutput("t2_word1_data",  dump_data, 64'h0000_0000_0000_1234);
        tick();
        checkOutput("t2_done", {63'd0, done}, 64'd1);
        dump_ready = 1'b0;
        tick();
        checkOutput("t2_idle", {63'd0, busy}, 64'd0);

        // Gapped load: valid every other cycle.
        applyStimulus(9'd4, 10'd0, 16'd0, 10'd0);
        for (int c = 0; c < 8; c++) begin
            ld_valid = (c % 2 == 0);
            ld_data  = {32'd0, 32'hA000_0000 + 32'(c / 2)};
            tick();
            if (c % 2 == 0) begin
                checkOutput($sformatf("t3_wen_c%0d", c), {63'd0, wen_ext}, 64'd1);
                checkOutput($sformatf("t3_addr_c%0d", c), addr_ext, 64'(4 * (c / 2)));
                checkOutput($sformatf("t3_wdata_c%0d", c), {32'd0, wdata_ext},
                            {32'd0, 32'hA000_0000 + 32'(c / 2)});
            end else begin
                checkOutput($sformatf("t3_idle_wen_c%0d", c), {63'd0, wen_ext}, 64'd0);
            end
        end
        ld_valid = 1'b0;
        checkOutput("t3_idle", {63'd0, busy}, 64'd0);

        // Abort on RUN cycle 3 of 10, then a complete restart.
        applyStimulus(9'd0, 10'd0, 16'd10, 10'd0);
        checkOutput("t4_run_c1", {63'd0, cpu_enable}, 64'd1);
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checkOutput("t4_abort_enable", {63'd0, cpu_enable}, 64'd0);
        checkOutput("t4_abort_busy",   {63'd0, busy}, 64'd0);
        done_c = 0;
        for (int w = 0; w < 4; w++) begin
            if (done) done_c++;
            tick();
        end
        checkOutput("t4_no_done", 64'(done_c), 64'd0);
        ld_valid   = 1'b1;
        dump_ready = 1'b1;
        applyStimulus(9'd1, 10'd1, 16'd3, 10'd1);
        runAndCount(60, 1'b0, en_c, done_c, wi_c, wd_c, dump_c, dword);
        checkOutput("t4_re_writes_i", 64'(wi_c), 64'd1);
        checkOutput("t4_re_writes_d", 64'(wd_c), 64'd1);
        checkOutput("t4_re_enable",   64'(en_c), 64'd3);
        checkOutput("t4_re_done",     64'(done_c), 64'd1);
        checkOutput("t4_re_dump_cnt", 64'(dump_c), 64'd1);
        checkOutput("t4_re_dump",     dword, BASE + 64'd1);
        ld_valid   = 1'b0;
        dump_ready = 1'b0;

        // Asynchronous reset in the middle of a data load.
        applyStimulus(9'd0, 10'd3, 16'd0, 10'd0);
        ld_valid = 1'b1;
        ld_data  = 64'hCAFE_F00D_CAFE_F00D;
        tick();
        checkOutput("t5_pre_wen2", {63'd0, wen_ext_2}, 64'd1);
        #2 arst_n = 1'b0;
        #1;
        checkOutput("t5_wen2",  {63'd0, wen_ext_2}, 64'd0);
        checkOutput("t5_addr2", addr_ext_2, 64'd0);
        checkOutput("t5_wdata2", wdata_ext_2, 64'd0);
        checkOutput("t5_dump_data", dump_data, 64'd0);
        checkOutput("t5_ld_ready", {63'd0, ld_ready}, 64'd0);
        checkOutput("t5_busy", {63'd0, busy}, 64'd0);
        ld_valid = 1'b0;
        @(negedge clk);
        arst_n = 1'b1;
        tick();
        applyStimulus(9'd0, 10'd0, 16'd0, 10'd0);
        checkOutput("t5_done_pulse", {63'd0, done}, 64'd1);
        tick();
        checkOutput("t5_done_clear", {63'd0, done}, 64'd0);
        checkOutput("t5_idle",       {63'd0, busy}, 64'd0);

        // Full sequence with every stage active; start poked during RUN.
        ld_valid   = 1'b1;
        dump_ready = 1'b1;
        applyStimulus(9'd2, 10'd2, 16'd4, 10'd1);
        runAndCount(80, 1'b1, en_c, done_c, wi_c, wd_c, dump_c, dword);
        checkOutput("t6_writes_i", 64'(wi_c), 64'd2);
        checkOutput("t6_writes_d", 64'(wd_c), 64'd2);
        checkOutput("t6_enable",   64'(en_c), 64'd4);
        checkOutput("t6_done",     64'(done_c), 64'd1);
        checkOutput("t6_dump_cnt", 64'(dump_c), 64'd1);
        checkOutput("t6_dump",     dword, BASE + 64'd2);
        ld_valid   = 1'b0;
        dump_ready = 1'b0;
        tick();
        tick();
        checkOutput("t6_stays_idle", {63'd0, busy}, 64'd0);

        checkOutput("exclusion_violations", 64'(excl_viol), 64'd0);
        checkOutput("addr_upper_bits",      64'(addr_viol), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
